// File: rtl/idli_fetch_m_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : idli_fetch_m_pkg
//  Description : Shared types and constants for the idli fetch front end and
//                its SQI SRAM read sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
package idli_fetch_m_pkg;

  // Existing core types: 2-bit period counter and 16-bit data word.
  typedef logic [1:0]  ctr_t;
  typedef logic [15:0] data_t;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    STREAM = 3'd4
  } fe_state_t;

  // SQI sequential READ opcode, sent as two nibbles, high nibble first.
  localparam logic [7:0] SQI_CMD_READ   = 8'h03;
  localparam logic [2:0] SQI_CMD_NIBS   = 3'd2;
  // 24-bit byte address is six nibbles.
  localparam logic [2:0] SQI_ADDR_NIBS  = 3'd6;
  // Turnaround cycles between the last address nibble and the first data nibble.
  localparam logic [2:0] SQI_DUMMY_NIBS = 3'd2;

  // Counter phase whose ending edge may launch a new read, and the phase on
  // which the fourth nibble of a word is on the bus.
  localparam ctr_t CTR_START = 2'd1;
  localparam ctr_t CTR_LAST  = 2'd3;

  // The SRAM is byte addressed; instruction words are two bytes.
  function automatic logic [23:0] sqi_byte_addr(input data_t a);
    return {7'b0, a, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/idli_fetch_m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : idli_fetch_m
//  Description : Instruction fetch front end. Owns the period counter, runs an
//                SQI sequential READ against the SRAM and assembles four data
//                nibbles per period into a 16-bit instruction word. A redirect
//                ends the burst and restarts the read at a new word address.
//  Revision    : 1.0 - initial release
// ============================================================================
module idli_fetch_m #(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        i_fe_gck,
  input  logic        i_de_rst_n,
  input  logic        i_fe_redirect,
  input  logic [15:0] i_fe_redirect_addr,
  output logic [1:0]  o_fe_ctr,
  output logic [15:0] o_fe_enc,
  output logic        o_fe_enc_vld,
  output logic [15:0] o_fe_pc,
  output logic        o_sqi_cs_n,
  output logic [3:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio
);

  import idli_fetch_m_pkg::*;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  ctr_t        r_ctr;
  fe_state_t   r_state;
  logic [2:0]  r_nib;
  data_t       r_addr;
  data_t       r_pc;
  logic [11:0] r_buf;
  logic [2:0]  r_have;
  logic        r_cs_n;
  logic [3:0]  r_sio;
  logic        r_oe;

  fe_state_t   w_state_nxt;
  logic [2:0]  w_nib_nxt;
  logic [23:0] w_baddr;
  logic [3:0]  w_addr_nib;
  logic [3:0]  w_sio_nxt;
  logic        w_word_full;

  // Free-running period counter; only reset clears it, redirect never does.
  always_ff @(posedge i_fe_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      r_ctr <= '0;
    end else begin
      r_ctr <= r_ctr + 2'd1;
    end
  end

  // Next state and nibble index. Redirect wins over everything. Leaving IDLE
  // needs a whole ctr==1 cycle spent in IDLE, which fixes CMD on ctr==2 (so
  // the first data nibble lands on ctr==0) and guarantees cs_n high >= 1 cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_nib_nxt   = r_nib + 3'd1;
    if (i_fe_redirect) begin
      w_state_nxt = IDLE;
      w_nib_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nib_nxt = '0;
          if (r_ctr == CTR_START) begin
            w_state_nxt = CMD;
          end
        end
        CMD: begin
          if (r_nib == SQI_CMD_NIBS - 3'd1) begin
            w_state_nxt = ADDR;
            w_nib_nxt   = '0;
          end
        end
        ADDR: begin
          if (r_nib == SQI_ADDR_NIBS - 3'd1) begin
            w_state_nxt = DUMMY;
            w_nib_nxt   = '0;
          end
        end
        DUMMY: begin
          if (r_nib == SQI_DUMMY_NIBS - 3'd1) begin
            w_state_nxt = STREAM;
            w_nib_nxt   = '0;
          end
        end
        STREAM: begin
          w_nib_nxt = '0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_nib_nxt   = '0;
        end
      endcase
    end
  end

  // Address nibble select: MSB nibble of the byte address goes out first.
  always_comb begin
    w_baddr    = sqi_byte_addr(r_addr);
    w_addr_nib = '0;
    case (w_nib_nxt)
      3'd0:    w_addr_nib = w_baddr[23:20];
      3'd1:    w_addr_nib = w_baddr[19:16];
      3'd2:    w_addr_nib = w_baddr[15:12];
      3'd3:    w_addr_nib = w_baddr[11:8];
      3'd4:    w_addr_nib = w_baddr[7:4];
      3'd5:    w_addr_nib = w_baddr[3:0];
      default: w_addr_nib = '0;
    endcase
  end

  // Nibble to drive in the coming cycle; the bus is released outside CMD/ADDR.
  always_comb begin
    w_sio_nxt = '0;
    case (w_state_nxt)
      CMD:     w_sio_nxt = (w_nib_nxt == 3'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
      ADDR:    w_sio_nxt = w_addr_nib;
      default: w_sio_nxt = '0;
    endcase
  end

  // Sequencer register with its pad outputs registered alongside, so cs_n,
  // sio and oe always describe the state of the current cycle.
  always_ff @(posedge i_fe_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      r_state <= IDLE;
      r_nib   <= '0;
      r_cs_n  <= 1'b1;
      r_sio   <= '0;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_nib   <= w_nib_nxt;
      r_cs_n  <= (w_state_nxt == IDLE);
      r_sio   <= w_sio_nxt;
      r_oe    <= (w_state_nxt == CMD) || (w_state_nxt == ADDR);
    end
  end

  // Read start address and presented-word PC. Both load on redirect; the PC
  // then steps once per completed STREAM period and wraps at 16 bits.
  always_ff @(posedge i_fe_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      r_addr <= RESET_ADDR;
      r_pc   <= RESET_ADDR;
    end else if (i_fe_redirect) begin
      r_addr <= i_fe_redirect_addr;
      r_pc   <= i_fe_redirect_addr;
    end else if ((r_state == STREAM) && (r_ctr == CTR_LAST)) begin
      r_pc   <= r_pc + 16'd1;
    end
  end

  // Capture nibbles 0-2 of the period and remember which arrived in STREAM.
  // Any redirect or non-STREAM cycle discards the partial word.
  always_ff @(posedge i_fe_gck or negedge i_de_rst_n) begin
    if (!i_de_rst_n) begin
      r_buf  <= '0;
      r_have <= '0;
    end else if (i_fe_redirect || (r_state != STREAM)) begin
      r_buf  <= '0;
      r_have <= '0;
    end else begin
      case (r_ctr)
        2'd0: begin
          r_buf[3:0] <= i_sqi_sio;
          r_have     <= 3'b001;
        end
        2'd1: begin
          r_buf[7:4] <= i_sqi_sio;
          r_have[1]  <= 1'b1;
        end
        2'd2: begin
          r_buf[11:8] <= i_sqi_sio;
          r_have[2]   <= 1'b1;
        end
        default: begin
          r_have <= '0;
        end
      endcase
    end
  end

  // Word is complete when the three buffered nibbles all came from this
  // STREAM period; the fourth is taken straight off the bus.
  always_comb begin
    w_word_full  = &r_have;
    o_fe_enc     = {i_sqi_sio, r_buf};
    o_fe_enc_vld = (r_state == STREAM) && (r_ctr == CTR_LAST) && w_word_full && !i_fe_redirect;
  end

  assign o_fe_ctr     = r_ctr;
  assign o_fe_pc      = r_pc;
  assign o_sqi_cs_n   = r_cs_n;
  assign o_sqi_sio    = r_sio;
  assign o_sqi_sio_oe = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_idli_fetch_m
//  Description : Directed self-checking bench for idli_fetch_m with a small
//                SQI SRAM model that decodes the READ and streams words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idli_fetch_m;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [15:0] raddr;
  logic [1:0]  o_fe_ctr;
  logic [15:0] o_fe_enc;
  logic        o_fe_enc_vld;
  logic [15:0] o_fe_pc;
  logic        o_sqi_cs_n;
  logic [3:0]  o_sqi_sio;
  logic        o_sqi_sio_oe;
  logic [3:0]  m_sio;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  idli_fetch_m #(.RESET_ADDR(16'h0000)) u_dut (
    .i_fe_gck           (clk),
    .i_de_rst_n         (rst_n),
    .i_fe_redirect      (redirect),
    .i_fe_redirect_addr (raddr),
    .o_fe_ctr           (o_fe_ctr),
    .o_fe_enc           (o_fe_enc),
    .o_fe_enc_vld       (o_fe_enc_vld),
    .o_fe_pc            (o_fe_pc),
    .o_sqi_cs_n         (o_sqi_cs_n),
    .o_sqi_sio          (o_sqi_sio),
    .o_sqi_sio_oe       (o_sqi_sio_oe),
    .i_sqi_sio          (m_sio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents: word 0 is fixed, the rest follow a simple pattern.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'hA5C3;
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'h96};
  endfunction

  // SRAM model: updates just after each rising edge. Captures opcode and
  // address, waits two dummy cycles, then streams nibbles low-first per word.
  int          m_cnt = 0;
  logic [31:0] m_sh  = '0;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_baddr = '0;
  initial m_sio = 4'h0;
  always @(posedge clk) begin
    logic [15:0] w;
    logic [15:0] word;
    int k;
    #1;
    if (o_sqi_cs_n) begin
      m_cnt = 0;
      m_sio = 4'h0;
    end else begin
      if (m_cnt < 8) begin
        m_sh = {m_sh[27:0], o_sqi_sio};
        if (m_cnt == 7) begin
          m_cmd   = m_sh[31:24];
          m_baddr = m_sh[23:0];
        end
      end
      if (m_cnt >= 10) begin
        k     = m_cnt - 10;
        w     = m_baddr[16:1] + 16'(k / 4);
        word  = mem_word(w);
        m_sio = word[4*(k%4) +: 4];
      end else begin
        m_sio = 4'h0;
      end
      m_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s (cycle %0d) observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctr"},  32'(o_fe_ctr), 32'h0);
    chk({tag, "_csn"},  32'(o_sqi_cs_n), 32'h1);
    chk({tag, "_sio"},  32'(o_sqi_sio), 32'h0);
    chk({tag, "_oe"},   32'(o_sqi_sio_oe), 32'h0);
    chk({tag, "_vld"},  32'(o_fe_enc_vld), 32'h0);
    chk({tag, "_pc"},   32'(o_fe_pc), 32'h0);
  endtask

  // Eight CMD+ADDR cycles starting at c0; v holds the expected nibbles.
  task automatic seq_check(input string tag, input int c0, input logic [31:0] v);
    for (int j = 0; j < 8; j++) begin
      go(c0 + j);
      chk({tag, "_csn"}, 32'(o_sqi_cs_n), 32'h0);
      chk({tag, "_oe"},  32'(o_sqi_sio_oe), 32'h1);
      chk({tag, "_sio"}, 32'(o_sqi_sio), 32'(v[31-4*j -: 4]));
    end
  endtask

  task automatic word_check(input string tag, input int c, input logic [15:0] pc);
    go(c);
    chk({tag, "_ctr"}, 32'(o_fe_ctr), 32'h3);
    chk({tag, "_vld"}, 32'(o_fe_enc_vld), 32'h1);
    chk({tag, "_pc"},  32'(o_fe_pc), 32'(pc));
    chk({tag, "_enc"}, 32'(o_fe_enc), 32'(mem_word(pc)));
  endtask

  // Release reset mid-cycle: that cycle is cycle 0, ended by the first edge.
  task automatic boot_seq(input string tag);
    rst_n = 1'b1;
    cyc   = 0;
    chk({tag, "_c0_ctr"}, 32'(o_fe_ctr), 32'h0);
    chk({tag, "_c0_csn"}, 32'(o_sqi_cs_n), 32'h1);
    go(1);
    chk({tag, "_c1_csn"}, 32'(o_sqi_cs_n), 32'h1);
    seq_check({tag, "_hdr"}, 2, 32'h0300_0000);
    go(10);
    chk({tag, "_dmy_oe"},  32'(o_sqi_sio_oe), 32'h0);
    chk({tag, "_dmy_csn"}, 32'(o_sqi_cs_n), 32'h0);
    go(11);
    chk({tag, "_dmy_vld"}, 32'(o_fe_enc_vld), 32'h0);
    word_check({tag, "_w0"}, 15, 16'h0000);
    word_check({tag, "_w1"}, 19, 16'h0001);
    word_check({tag, "_w2"}, 23, 16'h0002);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    redirect = 1'b0;
    raddr    = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    boot_seq("boot");

    // Redirect at the edge ending ctr==1, mid-stream.
    go(25);
    redirect = 1'b1;
    raddr    = 16'h1234;
    tick();
    redirect = 1'b0;
    chk("rd1_pc", 32'(o_fe_pc), 32'h1234);
    for (int c = 26; c <= 29; c++) begin
      go(c);
      chk("rd1_idle_csn", 32'(o_sqi_cs_n), 32'h1);
    end
    chk("rd1_idle_vld", 32'(o_fe_enc_vld), 32'h0);
    seq_check("rd1_hdr", 30, 32'h0300_2468);
    go(38);
    chk("rd1_cmd",   32'(m_cmd), 32'h03);
    chk("rd1_baddr", 32'(m_baddr), 32'h002468);
    go(42);
    chk("rd1_pre_vld", 32'(o_fe_enc_vld), 32'h0);
    word_check("rd1_w0", 43, 16'h1234);
    word_check("rd1_w1", 47, 16'h1235);

    // Redirect coincident with ctr==3 of a complete word.
    go(51);
    chk("rd2_pre_vld", 32'(o_fe_enc_vld), 32'h1);
    redirect = 1'b1;
    raddr    = 16'h1236;
    #1;
    chk("rd2_kill_vld", 32'(o_fe_enc_vld), 32'h0);
    tick();
    redirect = 1'b0;
    chk("rd2_pc",  32'(o_fe_pc), 32'h1236);
    chk("rd2_csn", 32'(o_sqi_cs_n), 32'h1);
    go(63);
    chk("rd2_dmy_vld", 32'(o_fe_enc_vld), 32'h0);
    word_check("rd2_w0", 67, 16'h1236);
    word_check("rd2_w1", 71, 16'h1237);

    // Back-to-back redirects on consecutive edges.
    go(72);
    redirect = 1'b1;
    raddr    = 16'h0010;
    tick();
    raddr    = 16'h0020;
    chk("bb_c73_csn", 32'(o_sqi_cs_n), 32'h1);
    tick();
    redirect = 1'b0;
    chk("bb_pc", 32'(o_fe_pc), 32'h0020);
    for (int c = 74; c <= 77; c++) begin
      go(c);
      chk("bb_idle_csn", 32'(o_sqi_cs_n), 32'h1);
    end
    seq_check("bb_hdr", 78, 32'h0300_0040);
    go(86);
    chk("bb_baddr", 32'(m_baddr), 32'h000040);
    word_check("bb_w0", 91, 16'h0020);

    // Async reset asserted during DUMMY of a fresh burst.
    go(92);
    redirect = 1'b1;
    raddr    = 16'h0005;
    tick();
    redirect = 1'b0;
    go(102);
    chk("ar_pre_csn", 32'(o_sqi_cs_n), 32'h0);
    chk("ar_pre_oe",  32'(o_sqi_sio_oe), 32'h0);
    chk("ar_pre_pc",  32'(o_fe_pc), 32'h0005);
    rst_n = 1'b0;
    #1;
    check_reset("ar");
    repeat (2) @(negedge clk);
    boot_seq("reboot");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
